// File: rtl/car_state_keeper.sv
// Architectural state register for the manual-drive controller, plus the
// turn-indicator blinker and the odometer that runs while the car is moving.
module car_state_keeper #(
    parameter int unsigned MS_DIV   = 100000,
    parameter int unsigned BLINK_MS = 500,
    parameter int unsigned MILE_MS  = 1000,
    parameter int unsigned MILE_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next_power,
    input  logic [1:0]        next_state,
    input  logic [3:0]        next_moving_state,
    input  logic              turn_left_req,
    input  logic              turn_right_req,
    output logic              power,
    output logic [1:0]        state,
    output logic [3:0]        moving_state,
    output logic              left_led,
    output logic              right_led,
    output logic [MILE_W-1:0] mileage
);

    typedef enum logic [1:0] {
        NSTART = 2'b00,
        START  = 2'b01,
        MOVING = 2'b10
    } run_state_e;

    localparam int unsigned MS_W = (MS_DIV   > 1) ? $clog2(MS_DIV)   : 1;
    localparam int unsigned BL_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam int unsigned MI_W = (MILE_MS  > 1) ? $clog2(MILE_MS)  : 1;

    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_MS - 1);
    localparam logic [MI_W-1:0] MI_LAST = MI_W'(MILE_MS - 1);

    logic              power_q,   power_d;
    run_state_e        state_q,   state_d;
    logic [3:0]        moving_q,  moving_d;
    logic              lreq_q,    lreq_d;
    logic              rreq_q,    rreq_d;
    logic [MS_W-1:0]   ms_cnt_q,  ms_cnt_d;
    logic [MI_W-1:0]   sub_q,     sub_d;
    logic [MILE_W-1:0] mileage_q, mileage_d;
    logic [BL_W-1:0]   blink_q,   blink_d;
    logic              phase_q,   phase_d;
    logic              ms_tick;
    logic              moving;

    always_comb begin
        power_d  = next_power;
        state_d  = NSTART;
        moving_d = '0;
        if (next_power && next_state != 2'b11) begin
            state_d = run_state_e'(next_state);
            if (next_state == MOVING && $onehot0(next_moving_state))
                moving_d = next_moving_state;
        end
        lreq_d = turn_left_req  & next_power;
        rreq_d = turn_right_req & next_power;

        ms_tick  = (ms_cnt_q == MS_LAST);
        ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 1'b1;

        // Motion is judged on the registered state, so a tick coinciding with
        // a power drop request still counts.
        moving    = power_q && (state_q == MOVING) && (moving_q != '0);
        sub_d     = sub_q;
        mileage_d = mileage_q;
        if (ms_tick && moving) begin
            if (sub_q == MI_LAST) begin
                sub_d = '0;
                if (mileage_q != '1)
                    mileage_d = mileage_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end

        blink_d = '0;
        phase_d = 1'b1;
        if (lreq_q | rreq_q) begin
            blink_d = blink_q;
            phase_d = phase_q;
            if (ms_tick) begin
                if (blink_q == BL_LAST) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            power_q   <= 1'b0;
            state_q   <= NSTART;
            moving_q  <= '0;
            lreq_q    <= 1'b0;
            rreq_q    <= 1'b0;
            ms_cnt_q  <= '0;
            sub_q     <= '0;
            mileage_q <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b1;
        end else begin
            power_q   <= power_d;
            state_q   <= state_d;
            moving_q  <= moving_d;
            lreq_q    <= lreq_d;
            rreq_q    <= rreq_d;
            ms_cnt_q  <= ms_cnt_d;
            sub_q     <= sub_d;
            mileage_q <= mileage_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
        end
    end

    assign power        = power_q;
    assign state        = state_q;
    assign moving_state = moving_q;
    assign left_led     = power_q & lreq_q & phase_q;
    assign right_led    = power_q & rreq_q & phase_q;
    assign mileage      = mileage_q;

endmodule
